// File: rtl/mdu_pkg.sv
// mdu_pkg: shared constants for the multiply/divide unit.
//   MDUOp encodings (also imported by the control decoder), default busy
//   cycle counts, FSM state type and small op-class helpers.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'b000;
  localparam logic [2:0] MDU_MULTU = 3'b001;
  localparam logic [2:0] MDU_DIV   = 3'b010;
  localparam logic [2:0] MDU_DIVU  = 3'b011;
  localparam logic [2:0] MDU_MTHI  = 3'b100;
  localparam logic [2:0] MDU_MTLO  = 3'b101;

  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic mdu_is_div(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_core.sv
// mdu_core: purely combinational 64-bit multiply/divide result.
//   i_a  : operand rs (dividend / multiplicand)
//   i_b  : operand rt (divisor / multiplier)
//   i_op : MDUOp encoding
//   o_hi : result for HI (product high word / remainder)
//   o_lo : result for LO (product low word / quotient)
//   o_wr : result should be written at commit (0 for divide by zero, non-arith ops)
module mdu_core
  import mdu_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [2:0]  i_op,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_wr
);

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_signed_div;
  logic [31:0] w_num;
  logic [31:0] w_den;
  logic [31:0] w_den_safe;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;

  // Sign-extending to 64 bits makes the low 64 bits of the unsigned product
  // equal to the two's-complement signed product.
  assign w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
  assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

  // Signed divide is done on magnitudes so 0x80000000 / -1 never overflows:
  // |0x80000000| is still 0x80000000 as unsigned, and negating it wraps back.
  assign w_signed_div = (i_op == MDU_DIV);
  assign w_num        = (w_signed_div && i_a[31]) ? (32'd0 - i_a) : i_a;
  assign w_den        = (w_signed_div && i_b[31]) ? (32'd0 - i_b) : i_b;
  assign w_den_safe   = (w_den == 32'd0) ? 32'd1 : w_den;
  assign w_q_mag      = w_num / w_den_safe;
  assign w_r_mag      = w_num % w_den_safe;

  always_comb begin
    o_hi = 32'd0;
    o_lo = 32'd0;
    o_wr = 1'b0;
    case (i_op)
      MDU_MULT: begin
        o_hi = w_prod_s[63:32];
        o_lo = w_prod_s[31:0];
        o_wr = 1'b1;
      end
      MDU_MULTU: begin
        o_hi = w_prod_u[63:32];
        o_lo = w_prod_u[31:0];
        o_wr = 1'b1;
      end
      MDU_DIV: begin
        o_lo = (i_a[31] ^ i_b[31]) ? (32'd0 - w_q_mag) : w_q_mag;
        o_hi = i_a[31] ? (32'd0 - w_r_mag) : w_r_mag;
        o_wr = (i_b != 32'd0);
      end
      MDU_DIVU: begin
        o_lo = w_q_mag;
        o_hi = w_r_mag;
        o_wr = (i_b != 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit with private HI/LO registers.
//   clk   : system clock
//   reset : synchronous active-low reset
//   A, B  : operands rs / rt
//   MDUOp : operation select (see mdu_pkg)
//   start : one-cycle issue strobe
//   busy  : operation in flight
//   HI/LO : architectural HI/LO registers
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | accepts start; MTHI/MTLO write at once, arith ops go to RUN
// ST_RUN  | counting down; result committed to HI/LO on the cnt==1 edge
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDUOp,
  input  logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  mdu_state_e       r_state;
  mdu_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_tmp_hi;
  logic [31:0]      r_tmp_lo;
  logic             r_tmp_wr;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  logic             w_issue;
  logic             w_commit;
  logic             w_mthi;
  logic             w_mtlo;
  logic [31:0]      w_core_hi;
  logic [31:0]      w_core_lo;
  logic             w_core_wr;

  mdu_core u_core (
    .i_a  (A),
    .i_b  (B),
    .i_op (MDUOp),
    .o_hi (w_core_hi),
    .o_lo (w_core_lo),
    .o_wr (w_core_wr)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_commit    = 1'b0;
    w_mthi      = 1'b0;
    w_mtlo      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          case (MDUOp)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
              w_issue     = 1'b1;
              w_state_nxt = ST_RUN;
            end
            MDU_MTHI: w_mthi = 1'b1;
            MDU_MTLO: w_mtlo = 1'b1;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        // start is deliberately ignored here; the stall logic should never
        // issue into a busy unit, but if it does nothing changes.
        if (r_cnt == CNT_W'(1)) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_tmp_hi <= 32'd0;
      r_tmp_lo <= 32'd0;
      r_tmp_wr <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) begin
        r_tmp_hi <= w_core_hi;
        r_tmp_lo <= w_core_lo;
        r_tmp_wr <= w_core_wr;
        r_cnt    <= mdu_is_div(MDUOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (r_state == ST_RUN) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_commit && r_tmp_wr) begin
        r_hi <= r_tmp_hi;
        r_lo <= r_tmp_lo;
      end
      if (w_mthi) r_hi <= A;
      if (w_mtlo) r_lo <= A;
    end
  end

  assign busy = (r_state == ST_RUN);
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: self-checking bench for mdu_unit. Directed scenarios for the
// documented corner cases followed by randomized traffic, all compared
// cycle by cycle against a behavioural model of HI/LO/busy.
module tb_mdu_unit;

  logic        clk;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  MDUOp;
  logic        start;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model state
  logic [31:0] m_hi, m_lo;
  logic [31:0] m_phi, m_plo;
  logic        m_pwr;
  int          m_left;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .MDUOp (MDUOp),
    .start (start),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Result from the arithmetic definitions, using 64-bit integer math.
  task automatic ref_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic wr, output logic [31:0] hi, output logic [31:0] lo);
    int sa, sb;
    longint p, q, r;
    longint unsigned pu, qu, ru;
    sa = a; sb = b;
    wr = 1'b1; hi = 32'd0; lo = 32'd0;
    case (op)
      3'd0: begin p = longint'(sa) * longint'(sb); hi = p[63:32]; lo = p[31:0]; end
      3'd1: begin pu = {32'd0, a} * {32'd0, b}; hi = pu[63:32]; lo = pu[31:0]; end
      3'd2: begin
        if (b == 0) wr = 1'b0;
        else begin
          q = longint'(sa) / longint'(sb);
          r = longint'(sa) % longint'(sb);
          lo = q[31:0]; hi = r[31:0];
        end
      end
      3'd3: begin
        if (b == 0) wr = 1'b0;
        else begin
          qu = {32'd0, a} / {32'd0, b};
          ru = {32'd0, a} % {32'd0, b};
          lo = qu[31:0]; hi = ru[31:0];
        end
      end
      default: wr = 1'b0;
    endcase
  endtask

  // Drive one cycle of inputs, advance the model across the edge, compare.
  task automatic step(input logic rst_n, input logic st, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    reset = rst_n; start = st; MDUOp = op; A = a; B = b;
    @(posedge clk);
    if (!rst_n) begin
      m_hi = 0; m_lo = 0; m_left = 0; m_pwr = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_pwr) begin m_hi = m_phi; m_lo = m_plo; end
    end else if (st) begin
      case (op)
        3'd0, 3'd1, 3'd2, 3'd3: begin
          ref_calc(op, a, b, m_pwr, m_phi, m_plo);
          m_left = (op <= 3'd1) ? 5 : 10;
        end
        3'd4: m_hi = a;
        3'd5: m_lo = a;
        default: ;
      endcase
    end
    #1;
    chk("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
    chk("hi", HI, m_hi);
    chk("lo", LO, m_lo);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 3'd7, 32'd0, 32'd0);
  endtask

  initial begin
    m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pwr = 0; m_left = 0;
    reset = 1'b0; start = 1'b0; MDUOp = 3'd7; A = 0; B = 0;
    step(1'b0, 1'b0, 3'd7, 0, 0);

    // MTHI then reset held two cycles
    step(1'b1, 1'b1, 3'd4, 32'h1234, 0);
    chk("mthi_direct", HI, 32'h1234);
    step(1'b0, 1'b0, 3'd7, 0, 0);
    step(1'b0, 1'b0, 3'd7, 0, 0);
    chk("rst_hi", HI, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // MULT -2 * 3
    step(1'b1, 1'b1, 3'd0, 32'hFFFFFFFE, 32'd3);
    idle(4);
    chk("mult_busy_last", {31'd0, busy}, 32'd1);
    idle(1);
    chk("mult_busy_fall", {31'd0, busy}, 32'd0);
    chk("mult_hi", HI, 32'hFFFFFFFF);
    chk("mult_lo", LO, 32'hFFFFFFFA);

    // MULTU same operands, issued back-to-back in the cycle busy fell
    step(1'b1, 1'b1, 3'd1, 32'hFFFFFFFE, 32'd3);
    chk("b2b_accept", {31'd0, busy}, 32'd1);
    idle(5);
    chk("multu_hi", HI, 32'h00000002);
    chk("multu_lo", LO, 32'hFFFFFFFA);

    // DIV -7 / 2, with an MTHI attempted while busy
    step(1'b1, 1'b1, 3'd2, 32'hFFFFFFF9, 32'd2);
    step(1'b1, 1'b1, 3'd4, 32'h5555_5555, 0);
    chk("mthi_busy_ignored", HI, 32'h00000002);
    idle(8);
    chk("div_busy_last", {31'd0, busy}, 32'd1);
    idle(1);
    chk("div_lo", LO, 32'hFFFFFFFD);
    chk("div_hi", HI, 32'hFFFFFFFF);

    // DIVU by zero leaves HI/LO alone
    step(1'b1, 1'b1, 3'd4, 32'hAA, 0);
    step(1'b1, 1'b1, 3'd5, 32'hBB, 0);
    step(1'b1, 1'b1, 3'd3, 32'd7, 32'd0);
    idle(10);
    chk("divz_hi", HI, 32'hAA);
    chk("divz_lo", LO, 32'hBB);

    // most-negative / -1
    step(1'b1, 1'b1, 3'd2, 32'h80000000, 32'hFFFFFFFF);
    idle(10);
    chk("ovf_lo", LO, 32'h80000000);
    chk("ovf_hi", HI, 32'h0);

    // MTLO while idle, and a reserved op
    step(1'b1, 1'b1, 3'd5, 32'hDEADBEEF, 0);
    chk("mtlo_lo", LO, 32'hDEADBEEF);
    step(1'b1, 1'b1, 3'd6, 32'h1111, 32'h2222);
    chk("nop_busy", {31'd0, busy}, 32'd0);

    // DIV aborted by reset in busy cycle 4
    step(1'b1, 1'b1, 3'd2, 32'd100, 32'd7);
    idle(3);
    step(1'b0, 1'b0, 3'd7, 0, 0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_lo", LO, 32'd0);
    idle(12);
    chk("abort_no_commit", LO, 32'd0);

    // randomized traffic
    for (int it = 0; it < 1500; it++) begin
      logic [31:0] a, b;
      logic [2:0]  op;
      logic        st, rn;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 16));
        3: b = 32'd0 - 32'($urandom_range(1, 16));
        default: ;
      endcase
      st = ($urandom_range(0, 9) < 6);
      rn = ($urandom_range(0, 199) != 0);
      step(rn, st, op, a, b);
    end
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit alongside the single-cycle ALU in the EX stage.
- Covers the MIPS arithmetic the ALU does not: MULT, MULTU, DIV, DIVU into private HI/LO registers, plus MTHI/MTLO writes.
- Exposes HI/LO for MFHI/MFLO.
- Raises busy so hazard logic stalls any later MDU instruction.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU, counted from the cycle after start.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU, counted from the cycle after start.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-low reset
- A  input  32  operand rs (dividend / multiplicand / MTHI-MTLO data)
- B  input  32  operand rt (divisor / multiplier)
- MDUOp  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others NOP
- start  input  1  one-cycle strobe: issue MDUOp this cycle
- busy  output  1  operation in flight
- HI  output  32  HI register
- LO  output  32  LO register

Behaviour:
- Reset (reset==0 at a rising edge): HI=0, LO=0, busy=0, cnt=0, pending results cleared. Reset mid-operation aborts the operation; HI/LO read 0 on the next cycle.
- States: IDLE, RUN.
- IDLE, start=1, MDUOp in {000..011}:
  - Latch computed result into tmp_hi/tmp_lo.
  - Load cnt = MULT_CYCLES or DIV_CYCLES.
  - Go to RUN; busy=1 from the next cycle.
- RUN: cnt decrements each cycle. At the cnt==1 edge, HI<=tmp_hi, LO<=tmp_lo, busy<=0, go to IDLE.
  - Issue at edge T: busy high during cycles T+1..T+N, where N is the op's cycle count.
  - New HI/LO visible in cycle T+N+1, the same cycle busy falls.
- HI/LO hold their old values throughout RUN.
- MULT: {HI,LO} = signed(A)*signed(B), 64-bit.
- MULTU: same, unsigned.
- DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
- DIVU: LO = unsigned quotient, HI = unsigned remainder.
- Divide by zero (B==0): busy sequence runs normally; HI/LO unchanged at commit.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- MTHI/MTLO in IDLE with start=1: HI (or LO) <= A at that edge. Zero latency, busy stays 0.
- start while busy (any MDUOp): ignored. The stall logic must prevent this; the unit must still not corrupt state.
- start with MDUOp 110/111: no effect.
- Back-to-back: start is accepted in the cycle busy falls, since the state is IDLE then.
- Result computation may be combinational at issue (* and / operators). cnt width is ceil(log2(max(MULT_CYCLES,DIV_CYCLES)+1)).

Decomposition:
- Shared package: MDUOp encodings (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO) and default cycle counts. The control decoder imports the same constants.
- Optional sub-module mdu_core: pure combinational 64-bit result compute, A, B, op -> {hi,lo}. It isolates signed/unsigned and divide-edge rules for unit testing.
- mdu_unit keeps the FSM, counter and HI/LO registers.

Test Plan:
- Reset held low 2 cycles after MTHI 0x1234 -> HI=0, LO=0, busy=0.
- MULT A=0xFFFFFFFE (-2), B=3 at edge T -> busy 1 for T+1..T+5; cycle T+6: HI=0xFFFFFFFF, LO=0xFFFFFFFA, busy=0.
- MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA after 5 busy cycles.
- DIV A=-7 (0xFFFFFFF9), B=2 -> 10 busy cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 with HI=0xAA, LO=0xBB -> HI/LO unchanged after 10 cycles.
- MTLO A=0xDEADBEEF while IDLE -> LO=0xDEADBEEF next cycle, busy never rises. MTHI issued while busy -> HI unaffected.
- DIV in flight, reset driven low in busy cycle 4 -> next cycle busy=0, HI=LO=0, no later commit. Back-to-back MULT issued in the cycle busy falls -> accepted.
